alu_result_trace_fifo: RTL and testbench
========================================

// Module: alu_result_trace_fifo
// PURPOSE
//   Retirement trace buffer downstream of Top. Captures each valid
//   memory-stage ALU result (AluResult_Memory) into a show-ahead FIFO.
//   Drains to a bench checker or debug port over a valid/ready handshake,
//   replacing ad-hoc $monitor printing. Counts results dropped while full.
// PARAMETERS
//   DATA_W  32  width of captured result
//   DEPTH   16  FIFO entries; power of two, >= 2
//   ADDR_W  4   log2(DEPTH)
// PORTS
//   Clk               in   1         clock, all logic on posedge
//   Reset             in   1         synchronous, active-high
//   AluResult_Memory  in   DATA_W    memory-stage ALU result
//   Result_Valid      in   1         capture strobe for AluResult_Memory
//   Flush             in   1         synchronous empty request
//   Trace_Ready       in   1         consumer accepts head entry
//   Trace_Valid       out  1         head entry present
//   Trace_Data        out  DATA_W    head entry result
//   Trace_Stamp       out  32        head entry cycle stamp (see CONFIGURATION)
//   Trace_Count       out  ADDR_W+1  occupancy, 0..DEPTH
//   Overflow          out  1         sticky: a result was dropped
//   Drop_Count        out  16        dropped results, saturates at 16'hFFFF
// BEHAVIOUR
//   - Reset=1 at posedge: rd/wr pointers, Trace_Count, Overflow, Drop_Count,
//     and stamp counter go to 0. Trace_Valid=0 the next cycle. Storage is
//     not cleared. Reset mid-stream discards all entries and pending pops.
//   - pop  = Trace_Valid & Trace_Ready.
//   - push = Result_Valid & (!full | pop) & !Flush.
//   - full = (Trace_Count == DEPTH). empty = (Trace_Count == 0).
//   - Trace_Valid = !empty. Trace_Data and Trace_Stamp come from the
//     registered head. Both are stable while Trace_Valid & !Trace_Ready.
//   - Latency: a push at edge N is visible at the head (if empty) after
//     edge N. Trace_Valid=1 in cycle N+1. No same-cycle bypass:
//     push into empty with Trace_Ready=1 does not pop that cycle.
//   - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0.
//     Trace_Count += push - pop.
//   - Full, with push and pop in the same cycle: both occur, count unchanged,
//     no drop.
//   - Drop: Result_Valid & full & !pop & !Flush. Sets Overflow (sticky until
//     Reset). Drop_Count +1, saturating.
//   - Flush=1: next cycle pointers equal, Trace_Count=0. Any same-cycle
//     push or pop is ignored and is not counted as a drop. Overflow and
//     Drop_Count are kept.
//   - Reset has priority over Flush; Flush has priority over push and pop.
//   - No combinational path from Trace_Ready to Trace_Valid or Trace_Data.
// CONFIGURATION
//   TRACE_TIMESTAMP_EN defined:
//     - 32-bit free-running cycle counter: 0 after Reset, +1 per cycle,
//       wraps. Not reset by Flush.
//     - Each push stores the counter value with the data. Trace_Stamp shows
//       the head entry's stamp.
//   TRACE_TIMESTAMP_EN undefined:
//     - No counter and no stamp storage. Trace_Stamp tied to 32'h0.
//   Port list is identical in both builds.
// TESTING
//   1 Reset 2 cycles, then idle -> Trace_Valid=0, Trace_Count=0,
//     Overflow=0, Drop_Count=0.
//   2 Push 5,10,15 on consecutive cycles, Trace_Ready=1 -> Trace_Data seq
//     5,10,15, first valid 1 cycle after first push, Trace_Count peaks <= 2.
//   3 Trace_Ready=0, push 18 values 1..18 (DEPTH=16) -> Trace_Count=16,
//     Overflow=1, Drop_Count=2. Drain gives 1..16 in order.
//   4 Full FIFO, Result_Valid=1 with value 99 and Trace_Ready=1 same cycle
//     -> count stays 16, no drop. 99 appears last after the drain.
//   5 Count=7, assert Flush with Result_Valid=1 -> next cycle Count=0,
//     Trace_Valid=0, Drop_Count unchanged.
//   6 TRACE_TIMESTAMP_EN: release Reset at cycle 0, push at cycles 3 and 8
//     -> stamps 3 and 8. Without the macro -> Trace_Stamp=0 throughout.

Source files
------------

// File: rtl/alu_result_trace_fifo.sv
// alu_result_trace_fifo: show-ahead trace FIFO for memory-stage ALU results with drop counting.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp with each entry.
module alu_result_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] AluResult_Memory,
    input  logic              Result_Valid,
    input  logic              Flush,
    input  logic              Trace_Ready,
    output logic              Trace_Valid,
    output logic [DATA_W-1:0] Trace_Data,
    output logic [31:0]       Trace_Stamp,
    output logic [ADDR_W:0]   Trace_Count,
    output logic              Overflow,
    output logic [15:0]       Drop_Count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic full, pop, push, drop;

    assign full        = Trace_Count == (ADDR_W+1)'(DEPTH);
    assign Trace_Valid = Trace_Count != '0;
    assign pop         = Trace_Valid & Trace_Ready;
    assign push        = Result_Valid & (!full | pop) & !Flush;
    assign drop        = Result_Valid & full & !pop & !Flush;
    // Head is read straight from storage at the registered read pointer, so
    // Trace_Ready never reaches Trace_Valid or Trace_Data combinationally.
    assign Trace_Data  = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            Trace_Count <= '0;
            Overflow    <= 1'b0;
            Drop_Count  <= '0;
        end else if (Flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            Trace_Count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            Trace_Count <= Trace_Count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            if (drop) Overflow <= 1'b1;
            if (drop && Drop_Count != 16'hFFFF) Drop_Count <= Drop_Count + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= AluResult_Memory;
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] stamp_cnt;
    logic [31:0] stamp_mem [DEPTH];

    assign Trace_Stamp = stamp_mem[rd_ptr];

    always_ff @(posedge Clk) begin
        stamp_cnt <= Reset ? 32'd0 : stamp_cnt + 32'd1;
        if (push) stamp_mem[wr_ptr] <= stamp_cnt;
    end
`else
    assign Trace_Stamp = 32'h0;
`endif
endmodule

// File: tb/tb_alu_result_trace_fifo.sv
// tb_alu_result_trace_fifo: directed checks of the ALU result trace FIFO.
// Stamp expectations follow TRACE_TIMESTAMP_EN.
module tb_alu_result_trace_fifo;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] AluResult_Memory = '0;
    logic        Result_Valid = 1'b0;
    logic        Flush = 1'b0;
    logic        Trace_Ready = 1'b0;
    logic        Trace_Valid;
    logic [31:0] Trace_Data;
    logic [31:0] Trace_Stamp;
    logic [4:0]  Trace_Count;
    logic        Overflow;
    logic [15:0] Drop_Count;
    int tests = 0;
    int failed = 0;

    alu_result_trace_fifo dut (
        .Clk(Clk), .Reset(Reset), .AluResult_Memory(AluResult_Memory),
        .Result_Valid(Result_Valid), .Flush(Flush), .Trace_Ready(Trace_Ready),
        .Trace_Valid(Trace_Valid), .Trace_Data(Trace_Data), .Trace_Stamp(Trace_Stamp),
        .Trace_Count(Trace_Count), .Overflow(Overflow), .Drop_Count(Drop_Count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] stamp_a, stamp_b;
`ifdef TRACE_TIMESTAMP_EN
        stamp_a = 32'd3;
        stamp_b = 32'd8;
`else
        stamp_a = 32'd0;
        stamp_b = 32'd0;
`endif
        tick();
        tick();
        Reset = 1'b0;
        tick();
        check("rst_valid", 32'(Trace_Valid), 0);
        check("rst_count", 32'(Trace_Count), 0);
        check("rst_ovf", 32'(Overflow), 0);
        check("rst_drop", 32'(Drop_Count), 0);

        Trace_Ready = 1'b1;
        Result_Valid = 1'b1;
        AluResult_Memory = 5;
        check("pre_push_valid", 32'(Trace_Valid), 0);
        tick();
        check("p1_valid", 32'(Trace_Valid), 1);
        check("p1_data", Trace_Data, 5);
        check("p1_count", 32'(Trace_Count), 1);
        AluResult_Memory = 10;
        tick();
        check("p2_data", Trace_Data, 10);
        check("p2_count", 32'(Trace_Count), 1);
        AluResult_Memory = 15;
        tick();
        check("p3_data", Trace_Data, 15);
        check("p3_count", 32'(Trace_Count), 1);
        Result_Valid = 1'b0;
        tick();
        check("p_empty_valid", 32'(Trace_Valid), 0);
        check("p_empty_count", 32'(Trace_Count), 0);

        Trace_Ready = 1'b0;
        Result_Valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            AluResult_Memory = 32'(i);
            tick();
        end
        check("full_count", 32'(Trace_Count), 16);
        check("full_ovf", 32'(Overflow), 1);
        check("full_drop", 32'(Drop_Count), 2);
        check("full_head", Trace_Data, 1);
        check("full_stable", Trace_Data, 1);

        AluResult_Memory = 99;
        Trace_Ready = 1'b1;
        tick();
        check("fpp_count", 32'(Trace_Count), 16);
        check("fpp_drop", 32'(Drop_Count), 2);
        Result_Valid = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            check("drain_data", Trace_Data, 32'(i));
            tick();
        end
        check("drain_last", Trace_Data, 99);
        tick();
        check("drain_empty", 32'(Trace_Valid), 0);

        Trace_Ready = 1'b0;
        Result_Valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            AluResult_Memory = 32'(100 + i);
            tick();
        end
        check("pre_flush_count", 32'(Trace_Count), 7);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        Result_Valid = 1'b0;
        check("flush_count", 32'(Trace_Count), 0);
        check("flush_valid", 32'(Trace_Valid), 0);
        check("flush_drop", 32'(Drop_Count), 2);
        check("flush_ovf", 32'(Overflow), 1);

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst2_ovf", 32'(Overflow), 0);
        check("rst2_drop", 32'(Drop_Count), 0);
        tick();
        tick();
        tick();
        Result_Valid = 1'b1;
        AluResult_Memory = 32'hA;
        tick();
        Result_Valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Result_Valid = 1'b1;
        AluResult_Memory = 32'hB;
        tick();
        Result_Valid = 1'b0;
        check("ts_data_a", Trace_Data, 32'hA);
        check("ts_stamp_a", Trace_Stamp, stamp_a);
        Trace_Ready = 1'b1;
        tick();
        check("ts_data_b", Trace_Data, 32'hB);
        check("ts_stamp_b", Trace_Stamp, stamp_b);
        tick();
        check("ts_empty", 32'(Trace_Valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
